rate_tick_controller: RTL and testbench

//  Run/stop/step sequencer and rate configurator for the slow-clock divider path.

---
 rtl/rate_tick_controller.sv | 146 ++++++++++++++
 tb/tb_rate_tick_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_controller.sv
// rate_tick_controller
//   Run/stop/step sequencer and rate selector for the slow-clock divider path.
//   Commands arrive over a valid/ready handshake. The block produces a 50% duty
//   Slow_Clock at one of four fixed rates and a one-cycle Tick on every rising
//   edge of Slow_Clock. A rate change requested while running is held back until
//   the next half-period boundary, so Slow_Clock never produces a runt pulse.
//
// Ports
//   Clk         in   system clock, all logic on posedge
//   Reset       in   asynchronous, active-high reset
//   Cmd_Valid   in   command present
//   Cmd_Ready   out  command can be accepted (combinational from state)
//   Cmd_Op      in   0=SET_RATE 1=RUN 2=STOP 3=STEP
//   Cmd_Rate    in   rate index for SET_RATE: 0=1Hz 1=2Hz 2=10Hz 3=1kHz
//   Slow_Clock  out  divided clock, registered
//   Tick        out  one-cycle pulse in the cycle Slow_Clock first reads 1
//   Running     out  high whenever the half-period counter is enabled
//
// State      | meaning
// -----------+-----------------------------------------------------------
// STOPPED    | counter and Slow_Clock hold; SET_RATE applies immediately
// RUNNING    | counter enabled; SET_RATE is deferred into RATE_PEND
// RATE_PEND  | still at old rate; new rate loads at the next terminal count
// STEPPING   | run until the next rising edge of Slow_Clock, then stop

module rate_tick_controller #(
  parameter int CLK_HZ = 100000000,
  parameter int CNT_W  = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [1:0] Cmd_Op,
  input  logic [1:0] Cmd_Rate,
  output logic       Slow_Clock,
  output logic       Tick,
  output logic       Running
);

  typedef enum logic [1:0] {
    ST_STOPPED   = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_RATE_PEND = 2'd2,
    ST_STEPPING  = 2'd3
  } state_t;

  localparam logic [1:0] OP_SET_RATE = 2'd0;
  localparam logic [1:0] OP_RUN      = 2'd1;
  localparam logic [1:0] OP_STOP     = 2'd2;
  localparam logic [1:0] OP_STEP     = 2'd3;

  // Half-period terminal counts for 1 Hz, 2 Hz, 10 Hz and 1 kHz.
  localparam logic [CNT_W-1:0] TERM_0 = CNT_W'(CLK_HZ / 2 - 1);
  localparam logic [CNT_W-1:0] TERM_1 = CNT_W'(CLK_HZ / 4 - 1);
  localparam logic [CNT_W-1:0] TERM_2 = CNT_W'(CLK_HZ / 20 - 1);
  localparam logic [CNT_W-1:0] TERM_3 = CNT_W'(CLK_HZ / 2000 - 1);

  state_t           state, state_n;
  logic [1:0]       rate, rate_n;
  logic [1:0]       pend, pend_n;
  logic [CNT_W-1:0] count, count_n;
  logic             slow_n, tick_n;
  logic [CNT_W-1:0] term;
  logic             en, tc, accept;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_STOPPED;
      rate       <= 2'd0;
      pend       <= 2'd0;
      count      <= '0;
      Slow_Clock <= 1'b0;
      Tick       <= 1'b0;
    end else begin
      state      <= state_n;
      rate       <= rate_n;
      pend       <= pend_n;
      count      <= count_n;
      Slow_Clock <= slow_n;
      Tick       <= tick_n;
    end
  end

  always_comb begin
    unique case (rate)
      2'd0:    term = TERM_0;
      2'd1:    term = TERM_1;
      2'd2:    term = TERM_2;
      default: term = TERM_3;
    endcase
  end

  assign Cmd_Ready = (state == ST_STOPPED) || (state == ST_RUNNING);
  assign Running   = (state != ST_STOPPED);
  assign en        = Running;
  assign tc        = en && (count == term);
  assign accept    = Cmd_Valid && Cmd_Ready;

  always_comb begin
    // The divider step is computed first; a coincident command then acts on
    // the post-toggle values (e.g. STOP on a terminal count leaves count at 0).
    state_n = state;
    rate_n  = rate;
    pend_n  = pend;
    count_n = en ? (tc ? '0 : count + CNT_W'(1)) : count;
    slow_n  = Slow_Clock ^ tc;
    tick_n  = tc && !Slow_Clock;

    unique case (state)
      ST_STOPPED: begin
        if (accept) begin
          unique case (Cmd_Op)
            OP_RUN:      state_n = ST_RUNNING;
            OP_STEP:     state_n = ST_STEPPING;
            OP_SET_RATE: begin
              rate_n  = Cmd_Rate;
              count_n = '0;
            end
            default:     ;
          endcase
        end
      end
      ST_RUNNING: begin
        if (accept) begin
          if (Cmd_Op == OP_STOP) begin
            state_n = ST_STOPPED;
          end else if (Cmd_Op == OP_SET_RATE) begin
            pend_n  = Cmd_Rate;
            state_n = ST_RATE_PEND;
          end
        end
      end
      ST_RATE_PEND: begin
        if (tc) begin
          rate_n  = pend;
          state_n = ST_RUNNING;
        end
      end
      default: begin
        if (tc && !Slow_Clock) state_n = ST_STOPPED;
      end
    endcase
  end

endmodule

// File: tb/tb_rate_tick_controller.sv
// Bench for rate_tick_controller at CLK_HZ=2000. A behavioural model tracks
// mode, rate and elapsed cycles of the current half period (derived from the
// output frequency), and every clock the DUT outputs are compared against it.
// Directed scenarios measure edge-to-edge distances against fixed numbers,
// then a long random command stream runs against the model.

module tb_rate_tick_controller;

  localparam int CLK_HZ = 2000;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Cmd_Valid = 1'b0;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Op = 2'd0;
  logic [1:0] Cmd_Rate = 2'd0;
  logic       Slow_Clock;
  logic       Tick;
  logic       Running;

  rate_tick_controller #(.CLK_HZ(CLK_HZ), .CNT_W(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Op     (Cmd_Op),
    .Cmd_Rate   (Cmd_Rate),
    .Slow_Clock (Slow_Clock),
    .Tick       (Tick),
    .Running    (Running)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=stopped 1=running 2=waiting for rate change 3=single step
  int m_mode, m_rate, m_pend, m_elapsed;
  bit m_level, m_tick;

  function automatic int half_period(input int r);
    int freq [4] = '{1, 2, 10, 1000};
    return CLK_HZ / (2 * freq[r]);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rate = 0; m_pend = 0; m_elapsed = 0;
    m_level = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit v, input int op, input int rt);
    bit active, ready, boundary, rise;
    active   = (m_mode != 0);
    ready    = (m_mode <= 1);
    boundary = active && (m_elapsed + 1 == half_period(m_rate));
    rise     = boundary && !m_level;
    if (active) m_elapsed = boundary ? 0 : m_elapsed + 1;
    if (boundary) m_level = !m_level;
    m_tick = rise;
    case (m_mode)
      0: if (v && ready) begin
           if (op == 1) m_mode = 1;
           else if (op == 3) m_mode = 3;
           else if (op == 0) begin m_rate = rt; m_elapsed = 0; end
         end
      1: if (v && ready) begin
           if (op == 2) m_mode = 0;
           else if (op == 0) begin m_pend = rt; m_mode = 2; end
         end
      2: if (boundary) begin m_rate = m_pend; m_mode = 1; end
      default: if (rise) m_mode = 0;
    endcase
  endtask

  task automatic compare_outputs();
    check_val("slow_clock", int'(Slow_Clock), int'(m_level));
    check_val("tick", int'(Tick), int'(m_tick));
    check_val("running", int'(Running), int'(m_mode != 0));
    check_val("cmd_ready", int'(Cmd_Ready), int'(m_mode <= 1));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare at +1.
  task automatic step_cycle(input bit v, input logic [1:0] op, input logic [1:0] rt);
    Cmd_Valid = v; Cmd_Op = op; Cmd_Rate = rt;
    @(posedge Clk);
    model_edge(v, int'(op), int'(rt));
    #1;
    compare_outputs();
  endtask

  // Asynchronous reset: outputs must reach reset values before any posedge.
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_val("rst_slow_clock", int'(Slow_Clock), 0);
    check_val("rst_tick", int'(Tick), 0);
    check_val("rst_running", int'(Running), 0);
    check_val("rst_cmd_ready", int'(Cmd_Ready), 1);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 2'd0, 2'd0);
  endtask

  task automatic cycles_to_tick(input int limit, output int n);
    n = 0;
    do begin
      step_cycle(1'b0, 2'd0, 2'd0);
      n++;
    end while (!Tick && n < limit);
  endtask

  int n;
  logic lvl;
  bit v;

  initial begin
    do_reset();

    // RUN from reset: first rise 1000 edges after acceptance, period 2000.
    step_cycle(1'b1, 2'd1, 2'd0);
    cycles_to_tick(1200, n);
    check_val("t1_first_rise", n, 1000);
    cycles_to_tick(2200, n);
    check_val("t1_period", n, 2000);

    // Counter now at 0 after the rise; 300 idle edges leave it at 300.
    idle(300);
    step_cycle(1'b1, 2'd0, 2'd3);
    n = 0;
    while (!Cmd_Ready && n < 2000) begin
      step_cycle(1'b0, 2'd0, 2'd0);
      n++;
    end
    check_val("t2_ready_low_cycles", n, 699);
    idle(40);

    // STOP at counter 400, idle 50, RUN: next toggle 599 edges after RUN.
    do_reset();
    step_cycle(1'b1, 2'd1, 2'd0);
    idle(400);
    step_cycle(1'b1, 2'd2, 2'd0);
    lvl = Slow_Clock;
    idle(50);
    check_val("t3_held_level", int'(Slow_Clock), int'(lvl));
    step_cycle(1'b1, 2'd1, 2'd0);
    n = 0;
    while (Slow_Clock == lvl && n < 1500) begin
      step_cycle(1'b0, 2'd0, 2'd0);
      n++;
    end
    check_val("t3_resume_toggle", n, 599);

    // STEP at 10 Hz: tick after 100 edges from low, 200 from high.
    do_reset();
    step_cycle(1'b1, 2'd0, 2'd2);
    step_cycle(1'b1, 2'd3, 2'd0);
    cycles_to_tick(400, n);
    check_val("t4_step_from_low", n, 100);
    idle(5);
    check_val("t4_held_high", int'(Slow_Clock), 1);
    step_cycle(1'b1, 2'd3, 2'd0);
    cycles_to_tick(400, n);
    check_val("t4_step_from_high", n, 200);

    // STOP held valid through a step: ignored until ready, then a no-op.
    step_cycle(1'b1, 2'd3, 2'd0);
    n = 0;
    do begin
      step_cycle(1'b1, 2'd2, 2'd0);
      n++;
    end while (Running && n < 400);
    check_val("t6_step_len_with_stop", n, 200);
    for (int i = 0; i < 5; i++) step_cycle(1'b1, 2'd2, 2'd0);
    check_val("t6_stopped_level", int'(Slow_Clock), 1);

    // Reset during RATE_PEND discards the pending rate.
    do_reset();
    step_cycle(1'b1, 2'd1, 2'd0);
    idle(20);
    step_cycle(1'b1, 2'd0, 2'd3);
    idle(30);
    check_val("t5_in_rate_pend", int'(Cmd_Ready), 0);
    do_reset();
    step_cycle(1'b1, 2'd1, 2'd0);
    cycles_to_tick(1200, n);
    check_val("t5_rise_after_reset", n, 1000);

    // Fast rate: tick every second edge.
    do_reset();
    step_cycle(1'b1, 2'd0, 2'd3);
    step_cycle(1'b1, 2'd1, 2'd0);
    idle(3);
    cycles_to_tick(10, n);
    check_val("fast_tick_spacing", n, 2);

    // Random command stream against the model.
    for (int i = 0; i < 40000; i++) begin
      if ($urandom_range(0, 14999) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 199) == 0);
        step_cycle(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
